// File: rtl/song_pkg.sv
// song_pkg: shared FSM state encoding and song entry field layout
package song_pkg;
  typedef enum logic [3:0] {
    S_IDLE, S_FETCH, S_WAIT_ROM, S_DECODE, S_DISPATCH, S_WAIT_BEATS, S_NEXT, S_END, S_DONE
  } state_t;
  localparam int VOICE_LSB = 0;
  localparam int VOICE_W = 2;
  localparam int DUR_LSB = 3;
  localparam logic [15:0] END_MARKER = '0;
endpackage

// File: rtl/beat_counter.sv
// beat_counter: counts beat strobes while enabled and flags when the count reaches duration
module beat_counter #(
  parameter int DUR_W = 6
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             clear,
  input  logic             enable,
  input  logic             beat,
  input  logic [DUR_W-1:0] duration,
  output logic             match
);
  logic [DUR_W-1:0] count;
  // count held at zero outside a rest; a beat that lands on the match cycle is discarded by the clear
  always_ff @(posedge clk) begin
    if (!reset_n || clear) count <= '0;
    else if (enable && beat) count <= count + 1'b1;
  end
  assign match = count == duration;
endmodule

// File: rtl/multi_voice_song_reader.sv
// multi_voice_song_reader: walks song ROM entries, dispatching notes to voices and timing rests
module multi_voice_song_reader
  import song_pkg::*;
#(
  parameter int SONG_BITS = 2,
  parameter int ADDR_BITS = 7,
  parameter int NUM_VOICES = 3,
  parameter int NOTE_W = 6,
  parameter int DUR_W = 6,
  localparam int ENTRY_W = 1 + NOTE_W + DUR_W + 3
) (
  input  logic                           clk,
  input  logic                           reset_n,
  input  logic                           play,
  input  logic                           loop_en,
  input  logic [SONG_BITS-1:0]           song,
  input  logic                           beat,
  input  logic [NUM_VOICES-1:0]          voice_ready,
  output logic [SONG_BITS+ADDR_BITS-1:0] rom_addr,
  input  logic [ENTRY_W-1:0]             rom_data,
  output logic [NOTE_W-1:0]              note,
  output logic [DUR_W-1:0]               duration,
  output logic [NUM_VOICES-1:0]          new_note,
  output logic                           song_done,
  output logic                           busy
);
  localparam int NOTE_LSB = DUR_LSB + DUR_W;
  localparam logic [ADDR_BITS-1:0] LAST = '1;
  state_t state;
  logic [SONG_BITS-1:0] song_q;
  logic [ADDR_BITS-1:0] index;
  logic [ENTRY_W-1:0] entry;
  logic [VOICE_W-1:0] voice;
  logic [NUM_VOICES-1:0] voice_sel;
  logic match, switch_song;
  assign voice = entry[VOICE_LSB +: VOICE_W];
  assign voice_sel = NUM_VOICES'(1) << voice;
  assign note = entry[NOTE_LSB +: NOTE_W];
  assign duration = entry[DUR_LSB +: DUR_W];
  assign busy = !(state inside {S_IDLE, S_DONE});
  assign switch_song = busy && play && song != song_q;
  assign new_note = (state == S_DISPATCH && play && !switch_song) ? voice_sel & voice_ready : '0;
  assign song_done = state == S_END && play && !switch_song;
  beat_counter #(.DUR_W(DUR_W)) u_beats (
    .clk(clk),
    .reset_n(reset_n),
    .clear(state != S_WAIT_BEATS),
    .enable(play),
    .beat(beat),
    .duration(duration),
    .match(match)
  );
  // sequencer: rom_addr is loaded on entry to FETCH so the ROM word lands during WAIT_ROM
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state <= S_IDLE;
      song_q <= '0;
      index <= '0;
      rom_addr <= '0;
      entry <= '0;
    end else if (switch_song || (state == S_IDLE && play)) begin
      song_q <= song;
      index <= '0;
      rom_addr <= {song, {ADDR_BITS{1'b0}}};
      state <= S_FETCH;
    end else if (state == S_DONE) begin
      if (!play) state <= S_IDLE;
    end else if (play) begin
      case (state)
        S_FETCH: state <= S_WAIT_ROM;
        S_WAIT_ROM: begin
          entry <= rom_data;
          state <= S_DECODE;
        end
        S_DECODE: state <= entry == ENTRY_W'(END_MARKER) ? S_END :
                           entry[ENTRY_W-1] ? S_WAIT_BEATS :
                           32'(voice) < NUM_VOICES ? S_DISPATCH : S_NEXT;
        S_DISPATCH: if (|new_note) state <= S_NEXT;
        S_WAIT_BEATS: if (match) state <= S_NEXT;
        S_NEXT: begin
          if (index == LAST) state <= S_END;
          else begin
            index <= index + 1'b1;
            rom_addr <= {song_q, index + 1'b1};
            state <= S_FETCH;
          end
        end
        S_END: begin
          index <= '0;
          if (loop_en) begin
            rom_addr <= {song_q, {ADDR_BITS{1'b0}}};
            state <= S_FETCH;
          end else state <= S_DONE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_multi_voice_song_reader.sv
// tb_multi_voice_song_reader: directed scenarios with hand-computed expectations
module tb_multi_voice_song_reader;
  logic clk = 0, reset_n = 0, play = 0, loop_en = 0, beat = 0;
  logic [1:0] song = 0;
  logic [2:0] voice_ready = 3'b111;
  logic [8:0] rom_addr;
  logic [15:0] rom_data;
  logic [5:0] note, duration;
  logic [2:0] new_note;
  logic song_done, busy;
  logic [15:0] mem [0:511];
  int errors = 0, checks = 0;

  multi_voice_song_reader dut (
    .clk(clk), .reset_n(reset_n), .play(play), .loop_en(loop_en), .song(song), .beat(beat),
    .voice_ready(voice_ready), .rom_addr(rom_addr), .rom_data(rom_data), .note(note),
    .duration(duration), .new_note(new_note), .song_done(song_done), .busy(busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) rom_data <= mem[rom_addr];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic beat_after(input int n);
    repeat (n - 1) tick();
    beat = 1;
    tick();
    beat = 0;
  endtask

  task automatic finish_rest(output logic [8:0] r0, output logic [8:0] r1, output logic [8:0] r2);
    repeat (9) tick();
    r0 = rom_addr;
    beat = 1;
    tick();
    beat = 0;
    tick();
    r1 = rom_addr;
    tick();
    r2 = rom_addr;
  endtask

  task automatic do_reset();
    reset_n = 0; play = 0; loop_en = 0; song = 0; voice_ready = 3'b111; beat = 0;
    repeat (3) tick();
    reset_n = 1;
  endtask

  task automatic test_reset();
    reset_n = 0; play = 1; song = 1;
    repeat (3) tick();
    checks++;
    if ({rom_addr, note, duration, new_note, song_done, busy} !== '0)
      begin errors++; $display("FAIL reset_outputs: addr=%h note=%h dur=%h nn=%b done=%b busy=%b expected all 0", rom_addr, note, duration, new_note, song_done, busy); end
    play = 0; reset_n = 1;
    for (int i = 0; i < 2; i++) begin
      tick();
      checks++;
      if (rom_addr !== 9'h000 || busy !== 1'b0)
        begin errors++; $display("FAIL reset_release_%0d: addr=%h busy=%b expected 000/0", i, rom_addr, busy); end
    end
  endtask

  task automatic test_single();
    logic [8:0] r0, r1, r2;
    int cnt;
    do_reset();
    song = 1; play = 1;
    tick();
    checks++;
    if (rom_addr !== 9'h080 || busy !== 1'b1) begin errors++; $display("FAIL fetch_addr: addr=%h busy=%b expected 080/1", rom_addr, busy); end
    repeat (2) tick();
    checks++;
    if (new_note !== 3'b000) begin errors++; $display("FAIL early_strobe: nn=%b expected 000", new_note); end
    tick();
    checks++;
    if (new_note !== 3'b100 || note !== 6'h0A || duration !== 6'd4)
      begin errors++; $display("FAIL dispatch: nn=%b note=%h dur=%0d expected 100/0a/4", new_note, note, duration); end
    tick();
    checks++;
    if (new_note !== 3'b000) begin errors++; $display("FAIL strobe_width: nn=%b expected 000", new_note); end
    tick();
    checks++;
    if (rom_addr !== 9'h081) begin errors++; $display("FAIL rest_fetch: addr=%h expected 081", rom_addr); end
    beat_after(10);
    beat_after(10);
    checks++;
    if (duration !== 6'd3) begin errors++; $display("FAIL rest_duration: dur=%0d expected 3", duration); end
    finish_rest(r0, r1, r2);
    checks++;
    if (r0 !== 9'h081 || r1 !== 9'h081 || r2 !== 9'h082)
      begin errors++; $display("FAIL rest_3_beats: addr=%h,%h,%h expected 081,081,082", r0, r1, r2); end
    repeat (3) tick();
    checks++;
    if (song_done !== 1'b1) begin errors++; $display("FAIL song_done_pulse: done=%b expected 1", song_done); end
    cnt = 0;
    repeat (5) begin tick(); cnt += int'(song_done); end
    checks++;
    if (cnt != 0 || busy !== 1'b0 || rom_addr !== 9'h082)
      begin errors++; $display("FAIL done_hold: extra_pulses=%0d busy=%b addr=%h expected 0/0/082", cnt, busy, rom_addr); end
  endtask

  task automatic test_loop();
    do_reset();
    song = 1; loop_en = 1; play = 1;
    repeat (6) tick();
    repeat (3) beat_after(10);
    repeat (5) tick();
    checks++;
    if (song_done !== 1'b1) begin errors++; $display("FAIL loop_done: done=%b expected 1", song_done); end
    tick();
    checks++;
    if (rom_addr !== 9'h080 || busy !== 1'b1) begin errors++; $display("FAIL loop_restart: addr=%h busy=%b expected 080/1", rom_addr, busy); end
    repeat (3) tick();
    checks++;
    if (new_note !== 3'b100 || note !== 6'h0A)
      begin errors++; $display("FAIL loop_second_dispatch: nn=%b note=%h expected 100/0a", new_note, note); end
  endtask

  task automatic test_stall();
    logic [8:0] r0, r1, r2;
    int cnt;
    do_reset();
    song = 1; voice_ready = 3'b011; play = 1;
    repeat (4) tick();
    cnt = 0;
    repeat (20) begin tick(); if (new_note !== 3'b000) cnt++; end
    checks++;
    if (cnt != 0) begin errors++; $display("FAIL stall_no_strobe: strobes=%0d expected 0", cnt); end
    voice_ready = 3'b111;
    #1;
    checks++;
    if (new_note !== 3'b100) begin errors++; $display("FAIL strobe_on_ready: nn=%b expected 100", new_note); end
    repeat (2) tick();
    checks++;
    if (rom_addr !== 9'h081) begin errors++; $display("FAIL stall_next: addr=%h expected 081", rom_addr); end
    beat_after(10);
    play = 0;
    beat_after(5);
    checks++;
    if (busy !== 1'b1 || new_note !== 3'b000 || rom_addr !== 9'h081)
      begin errors++; $display("FAIL pause_hold: busy=%b nn=%b addr=%h expected 1/000/081", busy, new_note, rom_addr); end
    play = 1;
    beat_after(10);
    finish_rest(r0, r1, r2);
    checks++;
    if (r0 !== 9'h081 || r1 !== 9'h081 || r2 !== 9'h082)
      begin errors++; $display("FAIL pause_extends_rest: addr=%h,%h,%h expected 081,081,082", r0, r1, r2); end
  endtask

  task automatic test_reset_mid();
    do_reset();
    song = 1; voice_ready = 3'b000; play = 1;
    repeat (4) tick();
    reset_n = 0;
    tick();
    checks++;
    if (busy !== 1'b0 || rom_addr !== 9'h000 || note !== 6'h00 || new_note !== 3'b000)
      begin errors++; $display("FAIL reset_mid: busy=%b addr=%h note=%h nn=%b expected 0/000/00/000", busy, rom_addr, note, new_note); end
    reset_n = 1; play = 0; voice_ready = 3'b111;
    tick();
    checks++;
    if (busy !== 1'b0 || new_note !== 3'b000)
      begin errors++; $display("FAIL reset_mid_abandon: busy=%b nn=%b expected 0/000", busy, new_note); end
  endtask

  task automatic test_switch();
    int sd;
    logic [2:0] nn;
    do_reset();
    song = 1; play = 1;
    repeat (11) tick();
    song = 3; sd = 0;
    tick();
    sd += int'(song_done);
    tick();
    checks++;
    if (rom_addr !== 9'h180) begin errors++; $display("FAIL switch_addr: addr=%h expected 180", rom_addr); end
    nn = 3'b000;
    repeat (3) begin tick(); nn |= new_note; sd += int'(song_done); end
    checks++;
    if (nn !== 3'b000 || rom_addr !== 9'h181)
      begin errors++; $display("FAIL voice3_dropped: nn=%b addr=%h expected 000/181", nn, rom_addr); end
    repeat (3) tick();
    checks++;
    if (new_note !== 3'b001 || note !== 6'h15)
      begin errors++; $display("FAIL switch_dispatch: nn=%b note=%h expected 001/15", new_note, note); end
    repeat (4) begin tick(); sd += int'(song_done); end
    checks++;
    if (sd != 0) begin errors++; $display("FAIL switch_no_done: pulses=%0d expected 0", sd); end
    tick();
    checks++;
    if (song_done !== 1'b1) begin errors++; $display("FAIL switch_song_end: done=%b expected 1", song_done); end
  endtask

  task automatic test_full_song();
    int n;
    bit wrapped;
    logic [2:0] nn;
    for (int i = 0; i < 128; i++) mem[i] = 16'h8000;
    do_reset();
    song = 0; play = 1;
    n = 0; wrapped = 0; nn = 3'b000;
    while (song_done !== 1'b1 && n < 1000) begin
      tick();
      n++;
      if (rom_addr >= 9'h080) wrapped = 1;
      nn |= new_note;
    end
    checks++;
    if (song_done !== 1'b1 || n != 641)
      begin errors++; $display("FAIL full_song_done: done=%b cycles=%0d expected 1/641", song_done, n); end
    checks++;
    if (rom_addr !== 9'h07F || wrapped || nn !== 3'b000)
      begin errors++; $display("FAIL full_song_no_wrap: addr=%h wrapped=%0d nn=%b expected 07f/0/000", rom_addr, wrapped, nn); end
    tick();
    checks++;
    if (busy !== 1'b0 || song_done !== 1'b0)
      begin errors++; $display("FAIL full_song_idle: busy=%b done=%b expected 0/0", busy, song_done); end
  endtask

  initial begin
    foreach (mem[i]) mem[i] = '0;
    mem[9'h080] = 16'h1422;
    mem[9'h081] = 16'h8018;
    mem[9'h180] = 16'h0A0B;
    mem[9'h181] = 16'h2A10;
    test_reset();
    test_single();
    test_loop();
    test_stall();
    test_reset_mid();
    test_switch();
    test_full_song();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
